// File: rtl/tag_sram_dma_pkg.sv
// Shared encodings and defaults for the tag SRAM DMA initiator.
package tag_sram_dma_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DEPTH_DEF  = 12288;

   localparam logic OP_FILL = 1'b0;
   localparam logic OP_COPY = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_RWAIT = 3'd2,
      ST_WR    = 3'd3,
      ST_FIN   = 3'd4
   } state_e;

endpackage

// File: rtl/tag_sram_dma_rwait_ctr.sv
// Read-latency down-counter: loaded when a read is accepted, expire marks the
// cycle on which avm_readdata is valid.
module tag_sram_dma_rwait_ctr #(
   parameter int READ_LATENCY = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   output logic expire
);

   localparam logic [1:0] LOAD = 2'(READ_LATENCY - 1);

   logic [1:0] cnt_q;
   logic [1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = LOAD;
      end else if (cnt_q != 2'd0) begin
         cnt_d = cnt_q - 2'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == 2'd0);

endmodule

// File: rtl/tag_sram_dma_master.sv
// Avalon-MM FILL/COPY engine driving the s1 port of the 12288 x 32 tag SRAM.
// Optional running write checksum is enabled by defining TAG_SRAM_DMA_CHECKSUM_EN.
module tag_sram_dma_master
   import tag_sram_dma_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DEPTH        = DEPTH_DEF,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic [31:0]       cmd_pattern,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       checksum,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_read,
   output logic              avm_write,
   output logic [3:0]        avm_byteenable,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   state_e            state_q, state_d;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [31:0]       pattern_q, pattern_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              accept_s;
   logic              reject_s;
   logic              rd_start_s;
   logic              rd_expire_s;
   logic [ADDR_W:0]   dst_end_s;
   logic [ADDR_W:0]   src_end_s;

   // Range check uses one extra bit so a range ending exactly at DEPTH is legal.
   assign dst_end_s = {1'b0, cmd_dst} + {1'b0, cmd_len};
   assign src_end_s = {1'b0, cmd_src} + {1'b0, cmd_len};
   assign reject_s  = (dst_end_s > DEPTH_W) || ((cmd_op == OP_COPY) && (src_end_s > DEPTH_W));
   assign accept_s  = cmd_valid && (state_q == ST_IDLE);

   tag_sram_dma_rwait_ctr #(
      .READ_LATENCY (READ_LATENCY)
   ) u_rwait_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (rd_start_s),
      .expire  (rd_expire_s)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_FILL;
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         pattern_q <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rem_q     <= rem_d;
         pattern_q <= pattern_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      src_d      = src_q;
      dst_d      = dst_q;
      rem_d      = rem_q;
      pattern_d  = pattern_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      rd_start_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               op_d      = cmd_op;
               src_d     = cmd_src;
               dst_d     = cmd_dst;
               rem_d     = cmd_len;
               pattern_d = cmd_pattern;
               if (reject_s) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else if (cmd_len == {ADDR_W{1'b0}}) begin
                  state_d = ST_FIN;
               end else if (cmd_op == OP_COPY) begin
                  state_d = ST_RD;
               end else begin
                  state_d = ST_WR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            if (!avm_waitrequest) begin
               rd_start_s = 1'b1;
               state_d    = ST_RWAIT;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_RWAIT: begin
            if (rd_expire_s) begin
               rdata_d = avm_readdata;
               state_d = ST_WR;
            end else begin
               state_d = ST_RWAIT;
            end
         end
         ST_WR: begin
            if (!avm_waitrequest) begin
               src_d = src_q + ADDR_W'(1);
               dst_d = dst_q + ADDR_W'(1);
               rem_d = rem_q - ADDR_W'(1);
               if (rem_q == ADDR_W'(1)) begin
                  state_d = ST_FIN;
               end else if (op_q == OP_COPY) begin
                  state_d = ST_RD;
               end else begin
                  state_d = ST_WR;
               end
            end else begin
               state_d = ST_WR;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus and status outputs decode purely from registered state, so they hold under waitrequest.
   always_comb begin
      cmd_ready      = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      avm_address    = '0;
      avm_chipselect = 1'b0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = 32'd0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
         end
         ST_RD: begin
            busy           = 1'b1;
            avm_chipselect = 1'b1;
            avm_read       = 1'b1;
            avm_address    = src_q;
         end
         ST_RWAIT: begin
            busy = 1'b1;
         end
         ST_WR: begin
            busy           = 1'b1;
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
            avm_address    = dst_q;
            avm_writedata  = (op_q == OP_FILL) ? pattern_q : rdata_q;
         end
         ST_FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
      avm_byteenable = avm_chipselect ? 4'hF : 4'h0;
   end

   assign err = err_q;

`ifdef TAG_SRAM_DMA_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (accept_s) begin
         checksum_d = 32'd0;
      end else if ((state_q == ST_WR) && !avm_waitrequest) begin
         checksum_d = checksum_q + avm_writedata;
      end else begin
         checksum_d = checksum_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         checksum_q <= 32'd0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_tag_sram_dma_master.sv
// Scoreboard bench for tag_sram_dma_master: stimulus queues expected bus/status
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_tag_sram_dma_master;
   import tag_sram_dma_pkg::*;

`ifdef TAG_SRAM_DMA_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   localparam int K_RD   = 0;
   localparam int K_WR   = 1;
   localparam int K_DONE = 2;
   localparam int K_ERR  = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [13:0] cmd_src;
   logic [13:0] cmd_dst;
   logic [13:0] cmd_len;
   logic [31:0] cmd_pattern;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] checksum;
   logic [13:0] avm_address;
   logic        avm_chipselect;
   logic        avm_read;
   logic        avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = 32'hBAD0_BAD0;
   logic        avm_waitrequest = 1'b0;

   typedef struct {
      int          kind;
      logic [13:0] addr;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   ev_t         exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          wr_acc = 0;
   int          stall_at = -1;
   int          stall_left = 0;
   logic [31:0] mem [0:15];
   logic        rd_pend = 1'b0;
   logic [13:0] rd_pend_addr = 14'd0;
   logic        prev_stalled = 1'b0;
   logic [13:0] prev_addr = 14'd0;
   logic [31:0] prev_data = 32'd0;

   tag_sram_dma_master dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_src         (cmd_src),
      .cmd_dst         (cmd_dst),
      .cmd_len         (cmd_len),
      .cmd_pattern     (cmd_pattern),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .checksum        (checksum),
      .avm_address     (avm_address),
      .avm_chipselect  (avm_chipselect),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_byteenable  (avm_byteenable),
      .avm_writedata   (avm_writedata),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [13:0] addr, input logic [31:0] data, input int c);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic match_event(input int kind, input logic [13:0] addr, input logic [31:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none (cycle %0d)",
                  kind, addr, data, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 32'(kind), 32'(e.kind));
         chk("event_cycle", 32'(cyc), 32'(e.cyc));
         if (e.kind == K_RD || e.kind == K_WR) begin
            chk("event_addr", 32'(addr), 32'(e.addr));
         end
         if (e.kind == K_WR) begin
            chk("event_wdata", data, e.data);
         end
      end
   endtask

   // Slave model and monitor: decide waitrequest, supply read data one cycle after accept, match events.
   always @(negedge clk) begin
      avm_readdata = rd_pend ? mem[rd_pend_addr[3:0]] : 32'hBAD0_BAD0;
      rd_pend = 1'b0;
      if (avm_write && stall_left > 0 && wr_acc == stall_at) begin
         avm_waitrequest = 1'b1;
         stall_left--;
      end else begin
         avm_waitrequest = 1'b0;
      end
      if (reset_n) begin
         chk("rd_wr_exclusive", 32'(avm_read & avm_write), 32'd0);
         chk("byteenable", 32'(avm_byteenable), avm_chipselect ? 32'hF : 32'h0);
         if (prev_stalled) begin
            chk("stall_hold_write", 32'(avm_write), 32'd1);
            chk("stall_hold_addr", 32'(avm_address), 32'(prev_addr));
            chk("stall_hold_data", avm_writedata, prev_data);
         end
         if (avm_chipselect && avm_write && !avm_waitrequest) begin
            wr_acc++;
            match_event(K_WR, avm_address, avm_writedata);
         end
         if (avm_chipselect && avm_read && !avm_waitrequest) begin
            rd_pend      = 1'b1;
            rd_pend_addr = avm_address;
            match_event(K_RD, avm_address, 32'd0);
         end
         if (done) match_event(K_DONE, 14'd0, 32'd0);
         if (err)  match_event(K_ERR, 14'd0, 32'd0);
      end
      prev_stalled = avm_write && avm_waitrequest;
      prev_addr    = avm_address;
      prev_data    = avm_writedata;
   end

   task automatic issue(input logic op, input logic [13:0] src, input logic [13:0] dst,
                        input logic [13:0] len, input logic [31:0] pat);
      cmd_op      = op;
      cmd_src     = src;
      cmd_dst     = dst;
      cmd_len     = len;
      cmd_pattern = pat;
      cmd_valid   = 1'b1;
      @(negedge clk);
      cmd_valid   = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: got cmd_ready 0 after 200 cycles, expected 1");
      end
   endtask

   initial begin
      int a;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
      mem[0] = 32'h0000_0011;
      mem[1] = 32'h0000_0022;
      mem[2] = 32'h0000_0033;
      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 1'b0;
      cmd_src     = 14'd0;
      cmd_dst     = 14'd0;
      cmd_len     = 14'd0;
      cmd_pattern = 32'd0;
      repeat (3) @(negedge clk);

      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_checksum", checksum, 32'd0);
      chk("rst_avm_ctrl", 32'({avm_chipselect, avm_read, avm_write, avm_byteenable}), 32'd0);
      chk("rst_avm_addr", 32'(avm_address), 32'd0);
      chk("rst_avm_wdata", avm_writedata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // FILL 4 words: back-to-back writes, done on the 5th cycle
      a = cyc;
      for (int i = 0; i < 4; i++) push(K_WR, 14'(16 + i), 32'hDEAD_BEEF, a + 1 + i);
      push(K_DONE, 14'd0, 32'd0, a + 5);
      issue(OP_FILL, 14'd0, 14'h0010, 14'd4, 32'hDEAD_BEEF);
      wait_idle();
      chk("fill_checksum", checksum, CK_EN ? 32'h7AB6_FBBC : 32'd0);

      // COPY 3 words: RD, RWAIT, WR per word
      a = cyc;
      for (int i = 0; i < 3; i++) begin
         push(K_RD, 14'(i), 32'd0, a + 1 + 3 * i);
         push(K_WR, 14'(256 + i), 32'(17 * (i + 1)), a + 3 + 3 * i);
      end
      push(K_DONE, 14'd0, 32'd0, a + 10);
      issue(OP_COPY, 14'h0000, 14'h0100, 14'd3, 32'hFFFF_FFFF);
      wait_idle();
      chk("copy_checksum", checksum, CK_EN ? 32'h0000_0066 : 32'd0);

      // Out-of-range FILL and COPY are rejected
      a = cyc;
      push(K_ERR, 14'd0, 32'd0, a + 1);
      issue(OP_FILL, 14'd0, 14'h2FFF, 14'd2, 32'h5555_5555);
      chk("rej_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rej_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("rej_cmd_ready_after", 32'(cmd_ready), 32'd1);
      a = cyc;
      push(K_ERR, 14'd0, 32'd0, a + 1);
      issue(OP_COPY, 14'h2FF0, 14'h0000, 14'h0020, 32'd0);
      @(negedge clk);

      // Last legal address
      a = cyc;
      push(K_WR, 14'h2FFF, 32'h5555_5555, a + 1);
      push(K_DONE, 14'd0, 32'd0, a + 2);
      issue(OP_FILL, 14'd0, 14'h2FFF, 14'd1, 32'h5555_5555);
      wait_idle();

      // Waitrequest held for 3 cycles on the second write
      stall_at   = wr_acc + 1;
      stall_left = 3;
      a = cyc;
      push(K_WR, 14'h0200, 32'h0F0F_A5A5, a + 1);
      push(K_WR, 14'h0201, 32'h0F0F_A5A5, a + 5);
      push(K_WR, 14'h0202, 32'h0F0F_A5A5, a + 6);
      push(K_DONE, 14'd0, 32'd0, a + 7);
      issue(OP_FILL, 14'd0, 14'h0200, 14'd3, 32'h0F0F_A5A5);
      wait_idle();

      // Reset during RWAIT aborts the COPY
      a = cyc;
      push(K_RD, 14'd1, 32'd0, a + 1);
      issue(OP_COPY, 14'd1, 14'h0300, 14'd2, 32'd0);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_avm_ctrl", 32'({avm_chipselect, avm_read, avm_write, avm_byteenable}), 32'd0);
      chk("midrst_avm_addr", 32'(avm_address), 32'd0);
      chk("midrst_avm_wdata", avm_writedata, 32'd0);
      chk("midrst_checksum", checksum, 32'd0);
      @(negedge clk);
      a = cyc;
      push(K_WR, 14'h0020, 32'h1234_5678, a + 1);
      push(K_WR, 14'h0021, 32'h1234_5678, a + 2);
      push(K_DONE, 14'd0, 32'd0, a + 3);
      issue(OP_FILL, 14'd0, 14'h0020, 14'd2, 32'h1234_5678);
      wait_idle();
      chk("post_rst_checksum", checksum, CK_EN ? 32'h2468_ACF0 : 32'd0);

      // Zero-length COPY: done next cycle, no bus traffic
      a = cyc;
      push(K_DONE, 14'd0, 32'd0, a + 1);
      issue(OP_COPY, 14'd5, 14'd6, 14'd0, 32'd0);
      wait_idle();

      repeat (3) @(negedge clk);
      chk("events_outstanding", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
